tt_um_coastalwhite_canright_sbox: RTL and testbench
===================================================

TT_UM_COASTALWHITE_CANRIGHT_SBOX -- requirements
Module: tt_um_coastalwhite_canright_sbox

Interface
REQ-001 SHALL have no parameters; all widths are fixed at 8 bits.
REQ-002 SHALL have port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port `rst`, input, 1 bit: reset, synchronous, active-high.
REQ-004 SHALL have port `ena`, input, 1 bit: design-select indication; ignored.
REQ-005 SHALL have port `ui_in`, input, 8 bits: write-data byte.
REQ-006 SHALL have port `uio_in`, input, 8 bits, decoded as follows:
- [3:0] register select (SEL);
- [7] unmasked trigger (TU);
- [6] masked trigger (TM);
- [5:4] unused.
REQ-007 SHALL have port `uo_out`, output, 8 bits: read-data byte selected by SEL.
REQ-008 SHALL have port `uio_out`, output, 8 bits: constant 0x00.
REQ-009 SHALL have port `uio_oe`, output, 8 bits: constant 0x00 (all uio pins are inputs).

Function
REQ-010 SHALL hold eight 8-bit registers:
- DATA, MIN (input mask), MOUT (output mask);
- R0, R1 (fresh randomness);
- SOUT (unmasked result), SSH (masked result share), SMK (masked result mask).
REQ-011 SHALL, on each rising edge with rst low, load ui_in into the register selected by SEL:
- 0001 -> DATA;
- 0011 -> MIN;
- 0100 -> MOUT;
- 0101 -> R0;
- 0110 -> R1;
- any other SEL value writes nothing.
REQ-012 SHALL, on each rising edge with TU=1, load SOUT <= S(DATA), where S is the AES forward S-box. DATA here is the register value before that edge.
REQ-013 SHALL compute S as GF(2^8) inversion via the Canright tower-field decomposition (GF(((2^2)^2)^2), normal basis), followed by the AES affine transform. Inverse of 0x00 maps to 0x00, giving S(0x00)=0x63.
REQ-014 SHALL, on each rising edge with TM=1, load from pre-edge register values:
- SSH <= S(DATA ^ MIN) ^ MOUT;
- SMK <= MOUT.
REQ-015 SHALL build the masked path as a shared (two-share) Canright datapath. R0/R1 refresh the nonlinear GF(2^4)/GF(2^2) multiplications. The unmasked value DATA^MIN SHALL never be formed on any wire or register.
REQ-016 SHALL make the masked result correct for any R0/R1 values: SSH ^ SMK = S(DATA ^ MIN).
REQ-017 SHALL update SOUT, SSH and SMK on every edge while the corresponding trigger is held high (level-sensitive), and hold them while it is low.
REQ-018 SHALL handle TU and TM high on the same edge by updating both independently.
REQ-019 SHALL handle a write and a trigger on the same edge as follows: the trigger uses the old register value, and the write takes effect for later edges.
REQ-020 SHALL drive uo_out combinationally from SEL:
- 0001 -> DATA;
- 1000 -> SOUT;
- 1001 -> SSH;
- 1010 -> SMK;
- all other SEL values (including mask/randomness selects) -> 0x00.
REQ-021 SHALL provide latency of one clock: a result is visible on uo_out in the cycle after the triggering edge, once SEL selects it.

Reset
REQ-022 SHALL, on a rising edge with rst=1, clear all eight registers to 0x00. Reset has priority over writes and triggers.
REQ-023 SHALL give these output values after reset:
- uo_out = 0x00 for every SEL;
- uio_out and uio_oe remain 0x00 at all times.
REQ-024 SHALL, when reset is asserted mid-operation (trigger held high), clear all results on that edge. Computation resumes on the first edge with rst low.

Verification
REQ-025 SHALL pass an exhaustive unmasked sweep: for each i in 0..255, with SEL=0001 and ui_in=i for one edge, then TU=1 for one edge, then SEL=1000 -> uo_out = AESSbox[i]. Spot values: i=0x00 -> 0x63, 0x53 -> 0xED, 0xFF -> 0x16.
REQ-026 SHALL pass an exhaustive masked sweep: with MIN=0x42, MOUT=0x13, R0=0x37, R1=0x15, for each i load DATA=i^0x42, pulse TM, then read SEL=1001 and SEL=1010 -> XOR of the two reads = AESSbox[i], and the SEL=1010 read = 0x13.
REQ-027 SHALL pass a masked spot check: with DATA=0x42 and the masks above -> SSH=0x70 and SMK=0x13.
REQ-028 SHALL pass a randomness independence check: repeat REQ-026 with R0/R1 = 0x00 and 0xFF -> identical SSH^SMK results.
REQ-029 SHALL pass a reset check: after any computation, one edge with rst=1 -> SEL=1000, 1001, 1010 and 0001 all read 0x00, and uio_oe=0x00.
REQ-030 SHALL pass a same-edge check: with DATA=0x00, write DATA=0x01 with TU=1 on the same edge -> SOUT=0x63; the next edge with TU=1 -> SOUT=0x7C.

Source files
------------

// File: rtl/tt_um_coastalwhite_canright_sbox.sv
// -----------------------------------------------------------------------------
// tt_um_coastalwhite_canright_sbox
//
// AES forward S-box built on the Canright tower-field inverter
// GF(((2^2)^2)^2), normal basis. The block holds two datapaths:
//   - an unmasked S-box:  SOUT <= S(DATA)
//   - a two-share masked S-box: SSH <= S(DATA ^ MIN) ^ MOUT, SMK <= MOUT.
//     The shares DATA and MIN are carried separately through the basis
//     change and the inverter. They are never combined. Each nonlinear
//     GF(2^4)/GF(2^2) multiplication is refreshed with bits of R0/R1.
//
// Ports
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset, clears all registers
//   ena      : design-select, ignored
//   ui_in    : write-data byte
//   uio_in   : [3:0] register select, [6] masked trigger, [7] unmasked trigger
//   uo_out   : read-data byte, combinational mux on register select
//   uio_out  : constant 0x00
//   uio_oe   : constant 0x00 (all uio pins are inputs)
//
// Register map (select -> write / read)
//   0001 DATA  w/r   0011 MIN  w   0100 MOUT w   0101 R0 w   0110 R1 w
//   1000 SOUT  r     1001 SSH  r   1010 SMK  r   everything else reads 0x00
// -----------------------------------------------------------------------------
module tt_um_coastalwhite_canright_sbox (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [3:0] SEL_DATA = 4'b0001;
  localparam logic [3:0] SEL_MIN  = 4'b0011;
  localparam logic [3:0] SEL_MOUT = 4'b0100;
  localparam logic [3:0] SEL_R0   = 4'b0101;
  localparam logic [3:0] SEL_R1   = 4'b0110;
  localparam logic [3:0] SEL_SOUT = 4'b1000;
  localparam logic [3:0] SEL_SSH  = 4'b1001;
  localparam logic [3:0] SEL_SMK  = 4'b1010;

  // Basis-change matrices, one byte per input bit (bit 7 in the top byte).
  // A2X: polynomial basis -> tower normal basis.
  // X2S: tower normal basis -> polynomial basis merged with the linear part
  //      of the AES affine transform (constant 0x63 added separately).
  localparam logic [63:0] A2X = {8'h98, 8'hf3, 8'hf2, 8'h48,
                                 8'h09, 8'h81, 8'ha9, 8'hff};
  localparam logic [63:0] X2S = {8'h58, 8'h2d, 8'h9e, 8'h0b,
                                 8'hdc, 8'h04, 8'h03, 8'h24};

  // ---------------------------------------------------------------------------
  // GF(2) matrix-vector product: XOR of the columns selected by v.
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] mvm(input logic [7:0] v, input logic [63:0] m);
    logic [7:0] acc;
    acc = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (v[k]) acc = acc ^ m[8*k +: 8];
    end
    return acc;
  endfunction

  // ---------------------------------------------------------------------------
  // GF(2^2), normal basis [W^2, W]
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] gf2_mul(input logic [1:0] g, input logic [1:0] d);
    logic hi, mid, lo;
    hi  = g[1] & d[1];
    mid = (g[1] ^ g[0]) & (d[1] ^ d[0]);
    lo  = g[0] & d[0];
    return {hi ^ mid, lo ^ mid};
  endfunction

  function automatic logic [1:0] gf2_sq(input logic [1:0] g);
    return {g[0], g[1]};
  endfunction

  // multiply by N = W^2
  function automatic logic [1:0] gf2_scl_n(input logic [1:0] g);
    return {g[0], g[1] ^ g[0]};
  endfunction

  // multiply by N^2 = W
  function automatic logic [1:0] gf2_scl_n2(input logic [1:0] g);
    return {g[1] ^ g[0], g[1]};
  endfunction

  // ---------------------------------------------------------------------------
  // GF(2^4) over GF(2^2), normal basis
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] gf4_mul(input logic [3:0] x, input logic [3:0] y);
    logic [1:0] ph, pm, pl, e;
    ph = gf2_mul(x[3:2], y[3:2]);
    pm = gf2_mul(x[3:2] ^ x[1:0], y[3:2] ^ y[1:0]);
    pl = gf2_mul(x[1:0], y[1:0]);
    e  = gf2_scl_n(pm);
    return {ph ^ e, pl ^ e};
  endfunction

  // square and scale by nu
  function automatic logic [3:0] gf4_sq_scl(input logic [3:0] x);
    logic [1:0] s, b;
    s = x[3:2] ^ x[1:0];
    b = gf2_sq(x[1:0]);
    return {gf2_sq(s), gf2_scl_n2(b)};
  endfunction

  function automatic logic [3:0] gf4_inv(input logic [3:0] x);
    logic [1:0] s, b, c, d;
    s = x[3:2] ^ x[1:0];
    b = gf2_mul(x[3:2], x[1:0]);
    c = gf2_scl_n(gf2_sq(s));
    d = gf2_sq(c ^ b);
    return {gf2_mul(d, x[1:0]), gf2_mul(d, x[3:2])};
  endfunction

  // GF(2^8) over GF(2^4); the tower formula naturally maps 0 to 0.
  function automatic logic [7:0] gf8_inv(input logic [7:0] x);
    logic [3:0] s, b, c, d;
    s = x[7:4] ^ x[3:0];
    b = gf4_mul(x[7:4], x[3:0]);
    c = gf4_sq_scl(s);
    d = gf4_inv(c ^ b);
    return {gf4_mul(d, x[3:0]), gf4_mul(d, x[7:4])};
  endfunction

  // ---------------------------------------------------------------------------
  // Two-share versions. Every shared value is returned as {share1, share0}.
  // Products expand bilinearly; the cross terms are folded in together with
  // a fresh random r, so each output share is randomised before it is used.
  // ---------------------------------------------------------------------------
  function automatic logic [3:0] sec_gf2_mul(input logic [1:0] x0, input logic [1:0] x1,
                                             input logic [1:0] y0, input logic [1:0] y1,
                                             input logic [1:0] r);
    logic [1:0] z0, z1;
    z0 = gf2_mul(x0, y0) ^ (gf2_mul(x0, y1) ^ r);
    z1 = gf2_mul(x1, y1) ^ (gf2_mul(x1, y0) ^ r);
    return {z1, z0};
  endfunction

  function automatic logic [7:0] sec_gf4_mul(input logic [3:0] x0, input logic [3:0] x1,
                                             input logic [3:0] y0, input logic [3:0] y1,
                                             input logic [3:0] r);
    logic [3:0] z0, z1;
    z0 = gf4_mul(x0, y0) ^ (gf4_mul(x0, y1) ^ r);
    z1 = gf4_mul(x1, y1) ^ (gf4_mul(x1, y0) ^ r);
    return {z1, z0};
  endfunction

  function automatic logic [7:0] sec_gf4_inv(input logic [3:0] x0, input logic [3:0] x1,
                                             input logic [1:0] rb, input logic [1:0] rh,
                                             input logic [1:0] rl);
    logic [1:0] s0, s1, c0, c1, d0, d1;
    logic [3:0] b, ph, pl;
    s0 = x0[3:2] ^ x0[1:0];
    s1 = x1[3:2] ^ x1[1:0];
    b  = sec_gf2_mul(x0[3:2], x1[3:2], x0[1:0], x1[1:0], rb);
    c0 = gf2_scl_n(gf2_sq(s0));
    c1 = gf2_scl_n(gf2_sq(s1));
    d0 = gf2_sq(c0 ^ b[1:0]);
    d1 = gf2_sq(c1 ^ b[3:2]);
    ph = sec_gf2_mul(d0, d1, x0[1:0], x1[1:0], rh);
    pl = sec_gf2_mul(d0, d1, x0[3:2], x1[3:2], rl);
    return {ph[3:2], pl[3:2], ph[1:0], pl[1:0]};
  endfunction

  // Randomness allocation:
  //   R0[3:0] outer b product, R0[7:4] outer high product, R1[3:0] outer low
  //   product, R1[5:4] inner b product, R1[7:6] inner high product,
  //   R0[5:4]^R1[1:0] inner low product.
  function automatic logic [15:0] sec_gf8_inv(input logic [7:0] x0, input logic [7:0] x1,
                                              input logic [7:0] r0, input logic [7:0] r1);
    logic [3:0] s0, s1, c0, c1;
    logic [7:0] b, d, ph, pl;
    s0 = x0[7:4] ^ x0[3:0];
    s1 = x1[7:4] ^ x1[3:0];
    b  = sec_gf4_mul(x0[7:4], x1[7:4], x0[3:0], x1[3:0], r0[3:0]);
    c0 = gf4_sq_scl(s0) ^ b[3:0];
    c1 = gf4_sq_scl(s1) ^ b[7:4];
    d  = sec_gf4_inv(c0, c1, r1[5:4], r1[7:6], r0[5:4] ^ r1[1:0]);
    ph = sec_gf4_mul(d[3:0], d[7:4], x0[3:0], x1[3:0], r0[7:4]);
    pl = sec_gf4_mul(d[3:0], d[7:4], x0[7:4], x1[7:4], r1[3:0]);
    return {ph[7:4], pl[7:4], ph[3:0], pl[3:0]};
  endfunction

  // ---------------------------------------------------------------------------
  // Registers and decode
  // ---------------------------------------------------------------------------
  logic [7:0] r_data, r_min, r_mout, r_r0, r_r1;
  logic [7:0] r_sout, r_ssh, r_smk;

  logic [3:0]  w_sel;
  logic        w_tu, w_tm;
  logic [7:0]  w_data_x, w_min_x, w_inv_u, w_sbox_u;
  logic [15:0] w_inv_sh;
  logic [7:0]  w_s0, w_s1, w_ssh;
  logic        w_unused;

  assign w_sel = uio_in[3:0];
  assign w_tu  = uio_in[7];
  assign w_tm  = uio_in[6];

  assign w_unused = &{1'b0, ena, uio_in[5:4]};

  // Unmasked path
  assign w_data_x = mvm(r_data, A2X);
  assign w_inv_u  = gf8_inv(w_data_x);
  assign w_sbox_u = mvm(w_inv_u, X2S) ^ 8'h63;

  // Masked path: DATA and MIN stay separate shares throughout. The affine
  // constant goes into one share only; MOUT is added to share 0 before
  // share 1 so the unmasked S-box output is not formed either.
  assign w_min_x  = mvm(r_min, A2X);
  assign w_inv_sh = sec_gf8_inv(w_data_x, w_min_x, r_r0, r_r1);
  assign w_s0     = mvm(w_inv_sh[7:0], X2S) ^ 8'h63;
  assign w_s1     = mvm(w_inv_sh[15:8], X2S);
  assign w_ssh    = (w_s0 ^ r_mout) ^ w_s1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= 8'h00;
      r_min  <= 8'h00;
      r_mout <= 8'h00;
      r_r0   <= 8'h00;
      r_r1   <= 8'h00;
      r_sout <= 8'h00;
      r_ssh  <= 8'h00;
      r_smk  <= 8'h00;
    end else begin
      case (w_sel)
        SEL_DATA: r_data <= ui_in;
        SEL_MIN:  r_min  <= ui_in;
        SEL_MOUT: r_mout <= ui_in;
        SEL_R0:   r_r0   <= ui_in;
        SEL_R1:   r_r1   <= ui_in;
        default:  ;
      endcase
      // Triggers see pre-edge register values, so a same-edge write only
      // affects later computations.
      if (w_tu) r_sout <= w_sbox_u;
      if (w_tm) begin
        r_ssh <= w_ssh;
        r_smk <= r_mout;
      end
    end
  end

  always_comb begin
    uo_out = 8'h00;
    case (w_sel)
      SEL_DATA: uo_out = r_data;
      SEL_SOUT: uo_out = r_sout;
      SEL_SSH:  uo_out = r_ssh;
      SEL_SMK:  uo_out = r_smk;
      default:  uo_out = 8'h00;
    endcase
  end

  assign uio_out = 8'h00;
  assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_tt_um_coastalwhite_canright_sbox.sv
module tb_tt_um_coastalwhite_canright_sbox;

  localparam logic [3:0] SEL_NONE = 4'b0000;
  localparam logic [3:0] SEL_DATA = 4'b0001;
  localparam logic [3:0] SEL_MIN  = 4'b0011;
  localparam logic [3:0] SEL_MOUT = 4'b0100;
  localparam logic [3:0] SEL_R0   = 4'b0101;
  localparam logic [3:0] SEL_R1   = 4'b0110;
  localparam logic [3:0] SEL_SOUT = 4'b1000;
  localparam logic [3:0] SEL_SSH  = 4'b1001;
  localparam logic [3:0] SEL_SMK  = 4'b1010;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  tt_um_coastalwhite_canright_sbox dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [7:0] exp_q [$];
  string      tag_q [$];
  logic [7:0] sbox_ref [256];
  logic [7:0] m_data;

  task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s observed=%02h expected=%02h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  // Reference S-box from log/antilog tables (generator 0x03) plus affine map.
  task automatic build_sbox();
    logic [7:0] exp_t [255];
    int         log_t [256];
    logic [7:0] p, inv, b, s;
    p = 8'h01;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = p;
      log_t[p] = i;
      p = p ^ xtime(p);
    end
    for (int x = 0; x < 256; x++) begin
      inv = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
      s = inv;
      b = inv;
      for (int k = 0; k < 4; k++) begin
        b = {b[6:0], b[7]};
        s = s ^ b;
      end
      sbox_ref[x] = s ^ 8'h63;
    end
  endtask

  task automatic push_exp(input string tag, input logic [7:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  // One clock edge with the given uio_in/ui_in applied.
  task automatic cyc(input logic [7:0] uio, input logic [7:0] ui);
    @(negedge clk);
    uio_in = uio;
    ui_in  = ui;
    if (uio[3:0] == SEL_DATA) m_data = ui;
    @(posedge clk);
  endtask

  task automatic write_reg(input logic [3:0] sel, input logic [7:0] v);
    cyc({4'h0, sel}, v);
  endtask

  task automatic trig(input logic [7:0] uio);
    cyc(uio, m_data);
  endtask

  // Select a register, let the mux settle, and compare against the oldest
  // scoreboard entry. ui_in carries the current DATA so a DATA select
  // rewrites the same value.
  task automatic read_chk(input logic [3:0] sel);
    string      tag;
    logic [7:0] exp;
    @(negedge clk);
    uio_in = {4'h0, sel};
    ui_in  = m_data;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_empty observed=%02h expected=none", uo_out);
    end else begin
      tag = tag_q.pop_front();
      exp = exp_q.pop_front();
      chk_eq(tag, uo_out, exp);
    end
  endtask

  task automatic masked_sweep(input logic [7:0] r0, input logic [7:0] r1, input string tag);
    write_reg(SEL_MIN,  8'h42);
    write_reg(SEL_MOUT, 8'h13);
    write_reg(SEL_R0,   r0);
    write_reg(SEL_R1,   r1);
    for (int i = 0; i < 256; i++) begin
      write_reg(SEL_DATA, 8'(i) ^ 8'h42);
      trig(8'h40);
      push_exp(tag, sbox_ref[i] ^ 8'h13);
      push_exp({tag, "_smk"}, 8'h13);
      read_chk(SEL_SSH);
      read_chk(SEL_SMK);
    end
  endtask

  logic [7:0] spot_in  [3] = '{8'h00, 8'h53, 8'hff};
  logic [7:0] spot_out [3] = '{8'h63, 8'hed, 8'h16};

  initial begin
    build_sbox();
    rst    = 1'b1;
    ena    = 1'b1;
    ui_in  = 8'h00;
    uio_in = 8'h00;
    m_data = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 16; s++) begin
      push_exp("reset_read", 8'h00);
      read_chk(4'(s));
    end
    chk_eq("reset_uio_oe", uio_oe, 8'h00);
    chk_eq("reset_uio_out", uio_out, 8'h00);

    for (int i = 0; i < 256; i++) begin
      write_reg(SEL_DATA, 8'(i));
      trig({SEL_NONE[3:0] == 4'h0 ? 8'h80 : 8'h80});
      push_exp("sbox_unmasked", sbox_ref[i]);
      read_chk(SEL_SOUT);
    end

    for (int k = 0; k < 3; k++) begin
      write_reg(SEL_DATA, spot_in[k]);
      trig(8'h80);
      push_exp("sbox_spot", spot_out[k]);
      read_chk(SEL_SOUT);
      push_exp("data_readback", spot_in[k]);
      read_chk(SEL_DATA);
    end

    masked_sweep(8'h37, 8'h15, "masked_r37_15");
    masked_sweep(8'h00, 8'h00, "masked_r00_00");
    masked_sweep(8'hff, 8'hff, "masked_rff_ff");

    write_reg(SEL_R0, 8'h37);
    write_reg(SEL_R1, 8'h15);
    write_reg(SEL_DATA, 8'h42);
    trig(8'h40);
    push_exp("masked_spot_ssh", 8'h70);
    push_exp("masked_spot_smk", 8'h13);
    read_chk(SEL_SSH);
    read_chk(SEL_SMK);

    // Both triggers on one edge
    write_reg(SEL_MIN,  8'h00);
    write_reg(SEL_MOUT, 8'h5a);
    write_reg(SEL_DATA, 8'h53);
    trig(8'hc0);
    push_exp("dual_sout", sbox_ref[8'h53]);
    push_exp("dual_ssh", sbox_ref[8'h53] ^ 8'h5a);
    push_exp("dual_smk", 8'h5a);
    read_chk(SEL_SOUT);
    read_chk(SEL_SSH);
    read_chk(SEL_SMK);

    // Hold while trigger low
    write_reg(SEL_DATA, 8'h10);
    trig(8'h80);
    write_reg(SEL_DATA, 8'h20);
    trig(8'h00);
    push_exp("hold_sout", sbox_ref[8'h10]);
    read_chk(SEL_SOUT);

    // Same-edge write and trigger
    write_reg(SEL_DATA, 8'h00);
    cyc(8'h81, 8'h01);
    push_exp("same_edge_old", 8'h63);
    read_chk(SEL_SOUT);
    trig(8'h80);
    push_exp("same_edge_new", 8'h7c);
    read_chk(SEL_SOUT);

    // Reset mid-operation with both triggers and a write pending
    @(negedge clk);
    rst    = 1'b1;
    uio_in = 8'hc1;
    ui_in  = 8'haa;
    @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    uio_in = 8'h00;
    m_data = 8'h00;
    push_exp("midrst_sout", 8'h00);
    push_exp("midrst_ssh", 8'h00);
    push_exp("midrst_smk", 8'h00);
    push_exp("midrst_data", 8'h00);
    read_chk(SEL_SOUT);
    read_chk(SEL_SSH);
    read_chk(SEL_SMK);
    read_chk(SEL_DATA);
    chk_eq("midrst_uio_oe", uio_oe, 8'h00);
    trig(8'h80);
    push_exp("post_rst_sout", 8'h63);
    read_chk(SEL_SOUT);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
